mcycle_unit: RTL and testbench
==============================

Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit that sits beside the Execute stage.
- It is the responder side of the pipeline's MCycle stall/flush protocol. It accepts M_StartE with operands and the destination register from Execute.
- While computing, it reports M_Busy and the reserved destination WA3R. It pulses M_Done for one cycle while presenting the result to the writeback mux.
- The hazard unit consumes M_Busy, M_Done and WA3R to stall dependent instructions and to hold the pipeline during result injection.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESETn  input  1  asynchronous active-low reset.
- M_Start  input  1  start request from the Execute stage (M_StartE).
- M_Op  input  2  operation: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- WA3  input  4  destination register of the starting instruction.
- M_Busy  output  1  computation in progress (M_BusyE).
- M_Done  output  1  one-cycle result-valid pulse (M_DoneE).
- WA3R  output  4  reserved destination register; valid while M_Busy or M_Done.
- Result1  output  WIDTH  low product word / quotient.
- Result2  output  WIDTH  high product word / remainder.

Behaviour:
- Reset (async, RESETn=0): state IDLE; M_Busy=0, M_Done=0, WA3R=0, Result1=0, Result2=0, counter=0, operand registers=0.
- States are IDLE, BUSY and DONE.
- IDLE: if M_Start=1 at a rising edge, capture Op, WA3, magnitudes of operands and result-sign flags, then go to BUSY with count=0. Otherwise stay in IDLE.
- BUSY: M_Busy=1. Perform one iteration per cycle:
  - multiply: shift-add, one multiplier bit per cycle;
  - divide: restoring, one quotient bit per cycle.
- After WIDTH iterations, go to DONE.
- Latency: start sampled at edge 0; M_Busy high in cycles 1..WIDTH; M_Done high in cycle WIDTH+1 only.
- DONE: M_Busy=0, M_Done=1. Result1/Result2 hold the sign-corrected final values. Next state is IDLE.
- Result1/Result2 stay stable from DONE until the next accepted start. WA3R holds the captured value through DONE and afterwards.
- M_Start in BUSY or DONE is ignored; this is a protocol violation that the hazard unit prevents.
- Signed multiply produces the full 2*WIDTH two's-complement product.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- Divisor 0 (any divide op): quotient all-ones, remainder = Operand1 unchanged; still full latency.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs at reset values. No M_Done is produced for the aborted op.

Optional Feature:
- Macro MCYCLE_EARLY_TERM_EN.
- Defined: a multiply goes to DONE as soon as the remaining unshifted multiplier bits are all zero (minimum 1 BUSY cycle). Results must equal the full-latency result. Divide latency is unchanged.
- Undefined: fixed WIDTH-cycle latency for all ops.

Decomposition:
- mcycle_pkg contains:
  - the M_Op encodings (MC_UMUL, MC_SMUL, MC_UDIV, MC_SDIV);
  - the state enum (IDLE/BUSY/DONE);
  - the divide-by-zero quotient constant.
- One sub-module, mcycle_signfix: combinational abs-value on input and negate-on-flag on output, instanced for operands and results.

Test Plan:
- Unsigned mul: Operand1=0xFFFFFFFF, Operand2=0x00000002, Op=00 → M_Done at cycle 33, Result1=0xFFFFFFFE, Result2=0x00000001; M_Busy high exactly cycles 1..32.
- Signed mul: Operand1=-7 (0xFFFFFFF9), Operand2=6, Op=01 → Result2:Result1 = 0xFFFFFFFF_FFFFFFD6; WA3=4'hA is held on WA3R through M_Done.
- Signed div: Operand1=-17, Operand2=5, Op=11 → Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFE (-2). Unsigned div 100/7 → quotient 14, remainder 2.
- Divide by zero: Operand1=0x12345678, Operand2=0, Op=10 → Result1=0xFFFFFFFF, Result2=0x12345678. Separately, 0x80000000 / 0xFFFFFFFF with Op=11 → Result1=0x80000000, Result2=0.
- M_Start re-asserted during BUSY with other operands → ignored, original result delivered. RESETn pulsed low at BUSY cycle 10 → all outputs 0 immediately and no M_Done follows.
- With MCYCLE_EARLY_TERM_EN: 5×3 unsigned → M_Done by cycle 4, Result1=15; without the macro M_Done is at cycle 33.

Source files
------------

// File: rtl/mcycle_unit_pkg.sv
// ============================================================================
// Module  : mcycle_pkg
// Purpose : Shared encodings for the multi-cycle multiply/divide unit:
//           M_Op codes, FSM state enum and the divide-by-zero quotient.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mcycle_pkg;

  // M_Op encodings
  localparam logic [1:0] MC_UMUL = 2'b00;
  localparam logic [1:0] MC_SMUL = 2'b01;
  localparam logic [1:0] MC_UDIV = 2'b10;
  localparam logic [1:0] MC_SDIV = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Quotient reported for any divide by zero (sliced to the operand width)
  localparam int unsigned      MC_MAX_W    = 128;
  localparam logic [MC_MAX_W-1:0] MC_DIV0_QUO = '1;

  function automatic logic mc_is_signed(input logic [1:0] op);
    return (op == MC_SMUL) || (op == MC_SDIV);
  endfunction

  function automatic logic mc_is_div(input logic [1:0] op);
    return (op == MC_UDIV) || (op == MC_SDIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcycle_unit_if.sv
// ============================================================================
// Module  : mcycle_unit_if
// Purpose : Start/operand/result bundle between Execute (master) and the
//           multi-cycle unit (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             M_Start;
  logic [1:0]       M_Op;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [3:0]       WA3;
  logic             M_Busy;
  logic             M_Done;
  logic [3:0]       WA3R;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;

  modport master (
    output M_Start, M_Op, Operand1, Operand2, WA3,
    input  M_Busy, M_Done, WA3R, Result1, Result2
  );

  modport slave (
    input  M_Start, M_Op, Operand1, Operand2, WA3,
    output M_Busy, M_Done, WA3R, Result1, Result2
  );
endinterface

`default_nettype wire

// File: rtl/mcycle_unit_signfix.sv
// ============================================================================
// Module  : mcycle_signfix
// Purpose : Conditional two's-complement negation. Used as abs() on the
//           operands (neg_i = sign bit of a signed operand) and as the
//           sign correction of the final results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/mcycle_unit.sv
// ============================================================================
// Module  : mcycle_unit
// Purpose : Iterative multiply (shift-add) / divide (restoring) unit, one
//           bit per cycle, with Busy/Done handshake toward the hazard unit.
//           Optional macro MCYCLE_EARLY_TERM_EN: a multiply finishes as soon
//           as the remaining multiplier bits are zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic          CLK,
  input  logic          RESETn,
  mcycle_unit_if.slave  bus
);

  mc_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 is_div_q;
  logic [3:0]           wa3_q;
  // acc: mul = running 2W product; div = {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // b: mul = multiplicand shifted left each step; div = divisor (low word)
  logic [2*WIDTH-1:0]   b_q, b_d;
  // m: remaining multiplier bits, shifted right each step
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 neg_q;      // negate product / quotient
  logic                 neg_rem_q;  // negate remainder (dividend sign)
  logic                 dz_q;       // divisor was zero
  logic [WIDTH-1:0]     res1_q, res2_q;

  logic                 sgn_in, neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH-1:0]     div_sub;
  logic                 div_ge;
  logic                 last_iter;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH-1:0]     res1_d, res2_d;

  // Operand magnitudes at start
  assign sgn_in = mc_is_signed(bus.M_Op);
  assign neg_a  = sgn_in & bus.Operand1[WIDTH-1];
  assign neg_b  = sgn_in & bus.Operand2[WIDTH-1];

  mcycle_signfix #(.W(WIDTH)) u_abs_a (.val_i(bus.Operand1), .neg_i(neg_a), .val_o(mag_a));
  mcycle_signfix #(.W(WIDTH)) u_abs_b (.val_i(bus.Operand2), .neg_i(neg_b), .val_o(mag_b));

  // One iteration of the selected algorithm
  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    m_d     = m_q;
    div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, b_q[WIDTH-1:0]});
    // remainder stays below the divisor, so W bits hold the difference
    div_sub = div_sh[WIDTH-1:0] - b_q[WIDTH-1:0];
    if (is_div_q) begin
      acc_d = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                     : {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = m_q[0] ? (acc_q + b_q) : acc_q;
      b_d   = b_q << 1;
      m_d   = m_q >> 1;
    end
  end

  // Decide whether this BUSY cycle is the final iteration
  always_comb begin
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MCYCLE_EARLY_TERM_EN
    if (!is_div_q && (m_d == '0)) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Sign correction of the value the last iteration produces
  mcycle_signfix #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_d), .neg_i(neg_q), .val_o(prod_fix));
  mcycle_signfix #(.W(WIDTH)) u_fix_quo (.val_i(acc_d[WIDTH-1:0]), .neg_i(neg_q), .val_o(quo_fix));
  mcycle_signfix #(.W(WIDTH)) u_fix_rem (.val_i(acc_d[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .val_o(rem_fix));

  // Select final result words for mul / div / divide-by-zero
  always_comb begin
    res1_d = prod_fix[WIDTH-1:0];
    res2_d = prod_fix[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res1_d = dz_q ? MC_DIV0_QUO[WIDTH-1:0] : quo_fix;
      res2_d = rem_fix;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.M_Start) state_d = BUSY;
      BUSY:    if (last_iter)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result latching
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      wa3_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      m_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      res1_q    <= '0;
      res2_q    <= '0;
    end else begin
      if (state_q == IDLE && bus.M_Start) begin
        cnt_q     <= '0;
        is_div_q  <= mc_is_div(bus.M_Op);
        wa3_q     <= bus.WA3;
        neg_q     <= neg_a ^ neg_b;
        neg_rem_q <= neg_a;
        dz_q      <= (bus.Operand2 == '0);
        if (mc_is_div(bus.M_Op)) begin
          acc_q <= {{WIDTH{1'b0}}, mag_a};
          b_q   <= {{WIDTH{1'b0}}, mag_b};
          m_q   <= '0;
        end else begin
          acc_q <= '0;
          b_q   <= {{WIDTH{1'b0}}, mag_a};
          m_q   <= mag_b;
        end
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
        acc_q <= acc_d;
        b_q   <= b_d;
        m_q   <= m_d;
        if (last_iter) begin
          res1_q <= res1_d;
          res2_q <= res2_d;
        end
      end
    end
  end

  assign bus.M_Busy  = (state_q == BUSY);
  assign bus.M_Done  = (state_q == DONE);
  assign bus.WA3R    = wa3_q;
  assign bus.Result1 = res1_q;
  assign bus.Result2 = res2_q;

endmodule

`default_nettype wire

// File: tb/tb_mcycle_unit.sv
// ============================================================================
// Module  : tb_mcycle_unit
// Purpose : Directed, table-driven bench for mcycle_unit plus hand-written
//           sequences for ignored restart and mid-operation reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcycle_unit;
  import mcycle_pkg::*;

  localparam int WIDTH = 32;

  logic CLK;
  logic RESETn;
  int   checks;
  int   failures;

  mcycle_unit_if #(.WIDTH(WIDTH)) bus ();

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  wa3;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  // Expected cycle (counted from the start edge) at which M_Done appears
  function automatic int exp_done(input logic [1:0] op, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = WIDTH;
    m = b;
`ifdef MCYCLE_EARLY_TERM_EN
    if (op == MC_UMUL || op == MC_SMUL) begin
      if (op == MC_SMUL && b[31]) m = -b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`else
    if (op[0] && m[0]) n = WIDTH;
`endif
    return n + 1;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] wa3);
    @(negedge CLK);
    bus.M_Op     = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.WA3      = wa3;
    bus.M_Start  = 1'b1;
    @(negedge CLK);   // now in cycle 1
    bus.M_Start  = 1'b0;
  endtask

  // Walks cycles from cycle 1; optionally re-asserts start at cycle 5
  task automatic wait_done(input bit inject, output int done_at, output int busy_cnt);
    done_at  = 0;
    busy_cnt = 0;
    for (int k = 1; k <= WIDTH + 8; k++) begin
      if (bus.M_Done) begin
        done_at = k;
        break;
      end
      if (bus.M_Busy) busy_cnt++;
      if (inject && k == 5) begin
        bus.M_Op     = MC_UMUL;
        bus.Operand1 = 32'd50;
        bus.Operand2 = 32'd3;
        bus.WA3      = 4'h3;
        bus.M_Start  = 1'b1;
      end else begin
        bus.M_Start  = 1'b0;
      end
      @(negedge CLK);
    end
    bus.M_Start = 1'b0;
  endtask

  initial begin
    int   done_at;
    int   busy_cnt;
    int   lat;
    bit   seen_done;
    bit   seen_busy;

    checks   = 0;
    failures = 0;

    //              op       a             b             wa3   r1            r2
    vecs[0]  = '{MC_UMUL, 32'hFFFFFFFF, 32'h00000002, 4'h1, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MC_SMUL, 32'hFFFFFFF9, 32'h00000006, 4'hA, 32'hFFFFFFD6, 32'hFFFFFFFF};
    vecs[2]  = '{MC_SDIV, 32'hFFFFFFEF, 32'h00000005, 4'h2, 32'hFFFFFFFD, 32'hFFFFFFFE};
    vecs[3]  = '{MC_UDIV, 32'd100,      32'd7,        4'h3, 32'd14,       32'd2};
    vecs[4]  = '{MC_UDIV, 32'h12345678, 32'h00000000, 4'h4, 32'hFFFFFFFF, 32'h12345678};
    vecs[5]  = '{MC_SDIV, 32'h80000000, 32'hFFFFFFFF, 4'h5, 32'h80000000, 32'h00000000};
    vecs[6]  = '{MC_UMUL, 32'd5,        32'd3,        4'h6, 32'd15,       32'd0};
    vecs[7]  = '{MC_SMUL, 32'h80000000, 32'h80000000, 4'h7, 32'h00000000, 32'h40000000};
    vecs[8]  = '{MC_SDIV, 32'd17,       32'hFFFFFFFB, 4'h8, 32'hFFFFFFFD, 32'h00000002};
    vecs[9]  = '{MC_SDIV, 32'hFFFFFFFB, 32'h00000000, 4'h9, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[10] = '{MC_SMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hB, 32'h00000001, 32'h00000000};
    vecs[11] = '{MC_UDIV, 32'hFFFFFFFF, 32'h00000001, 4'hC, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{MC_UMUL, 32'h00012345, 32'h00000000, 4'hD, 32'h00000000, 32'h00000000};

    RESETn       = 1'b0;
    bus.M_Start  = 1'b0;
    bus.M_Op     = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    bus.WA3      = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy",  {63'd0, bus.M_Busy}, 64'd0);
    check("reset_done",  {63'd0, bus.M_Done}, 64'd0);
    check("reset_wa3r",  {60'd0, bus.WA3R},   64'd0);
    check("reset_res1",  {32'd0, bus.Result1}, 64'd0);
    check("reset_res2",  {32'd0, bus.Result2}, 64'd0);
    RESETn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa3);
      wait_done(1'b0, done_at, busy_cnt);
      lat = exp_done(vecs[i].op, vecs[i].b);
      check($sformatf("v%0d_done_cycle", i), 64'(done_at), 64'(lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt), 64'(lat - 1));
      check($sformatf("v%0d_busy_in_done", i), {63'd0, bus.M_Busy}, 64'd0);
      check($sformatf("v%0d_wa3r", i), {60'd0, bus.WA3R}, {60'd0, vecs[i].wa3});
      check($sformatf("v%0d_res1", i), {32'd0, bus.Result1}, {32'd0, vecs[i].r1});
      check($sformatf("v%0d_res2", i), {32'd0, bus.Result2}, {32'd0, vecs[i].r2});
      @(negedge CLK);
      check($sformatf("v%0d_done_pulse", i), {63'd0, bus.M_Done}, 64'd0);
      check($sformatf("v%0d_res1_hold", i), {32'd0, bus.Result1}, {32'd0, vecs[i].r1});
      check($sformatf("v%0d_wa3r_hold", i), {60'd0, bus.WA3R}, {60'd0, vecs[i].wa3});
    end

    // Start re-asserted while busy must be ignored
    start_op(MC_UDIV, 32'd100, 32'd7, 4'h5);
    wait_done(1'b1, done_at, busy_cnt);
    check("restart_done_cycle", 64'(done_at), 64'(WIDTH + 1));
    check("restart_res1", {32'd0, bus.Result1}, 64'd14);
    check("restart_res2", {32'd0, bus.Result2}, 64'd2);
    check("restart_wa3r", {60'd0, bus.WA3R}, 64'h5);
    @(negedge CLK);
    check("restart_no_second_op", {63'd0, bus.M_Busy}, 64'd0);

    // Reset during BUSY cycle 10 aborts immediately, no Done follows
    start_op(MC_SMUL, 32'hFFFFFFF9, 32'h80000001, 4'hE);
    repeat (9) @(negedge CLK);   // cycle 10
    check("abort_busy_before", {63'd0, bus.M_Busy}, 64'd1);
    RESETn = 1'b0;
    #1;
    check("abort_busy",  {63'd0, bus.M_Busy}, 64'd0);
    check("abort_done",  {63'd0, bus.M_Done}, 64'd0);
    check("abort_wa3r",  {60'd0, bus.WA3R},   64'd0);
    check("abort_res1",  {32'd0, bus.Result1}, 64'd0);
    check("abort_res2",  {32'd0, bus.Result2}, 64'd0);
    @(negedge CLK);
    RESETn    = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    repeat (WIDTH + 8) begin
      @(negedge CLK);
      if (bus.M_Done) seen_done = 1'b1;
      if (bus.M_Busy) seen_busy = 1'b1;
    end
    check("abort_no_done", {63'd0, seen_done}, 64'd0);
    check("abort_no_busy", {63'd0, seen_busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
